// File: rtl/rvfi_regfile_check.sv
// rvfi_regfile_check: shadow register-file monitor for the RVFI retire bus.
// Tracks every retired rd write, checks rs1/rs2 reads against the shadow
// (with forwarding between retire channels of the same cycle), and checks
// that retire order numbers are contiguous. Errors appear on registered outputs.
module rvfi_regfile_check #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned NRET          = 1,
    parameter int unsigned NUM_REGS      = 32,
    parameter bit          STOP_ON_ERROR = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   check,
    input  logic [NRET-1:0]        rvfi_valid,
    input  logic [64*NRET-1:0]     rvfi_order,
    input  logic [5*NRET-1:0]      rvfi_rs1_addr,
    input  logic [5*NRET-1:0]      rvfi_rs2_addr,
    input  logic [XLEN*NRET-1:0]   rvfi_rs1_rdata,
    input  logic [XLEN*NRET-1:0]   rvfi_rs2_rdata,
    input  logic [5*NRET-1:0]      rvfi_rd_addr,
    input  logic [XLEN*NRET-1:0]   rvfi_rd_wdata,
    output logic                   err,
    output logic [3:0]             err_code,
    output logic [63:0]            err_order,
    output logic [1:0]             err_chan,
    output logic [CNT_W-1:0]       err_count,
    output logic [1:0]             state
);

    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [XLEN-1:0]       regs_q [NUM_REGS];
    logic [XLEN-1:0]       regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   written_q, written_d;
    logic [63:0]           exp_order_q, exp_order_d;
    logic                  err_q, err_d;
    logic [3:0]            err_code_q, err_code_d;
    logic [63:0]           err_order_q, err_order_d;
    logic [1:0]            err_chan_q, err_chan_d;
    logic [CNT_W-1:0]      err_count_q, err_count_d;

    // per-channel scratch values used inside the combinational walk
    logic [2:0]            nvalid;
    logic [2:0]            n_err;
    logic                  first_hit;
    logic [3:0]            first_code;
    logic [63:0]           first_order;
    logic [1:0]            first_chan;
    logic [63:0]           base_order;
    logic [CNT_W:0]        cnt_sum;
    logic [4:0]            rs1_a, rs2_a, rd_a;
    logic [XLEN-1:0]       rs1_v, rs2_v, rd_v;
    logic [63:0]           ord_c;
    logic                  rs1_bad, rs2_bad, range_bad;
    logic [3:0]            code_c;

    function automatic logic in_range(input logic [4:0] a);
        return ({27'd0, a} < NUM_REGS);
    endfunction

    assign err       = err_q;
    assign err_code  = err_code_q;
    assign err_order = err_order_q;
    assign err_chan  = err_chan_q;
    assign err_count = err_count_q;
    assign state     = state_q;

    // Walk retire channels in ascending order against a working copy of the
    // shadow so channel k sees the writes of lower valid channels; then derive
    // next FSM state, expected order and error registers.
    always_comb begin
        regs_d      = regs_q;
        written_d   = written_q;
        exp_order_d = exp_order_q;
        state_d     = state_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        err_order_d = err_order_q;
        err_chan_d  = err_chan_q;
        err_count_d = err_count_q;
        nvalid      = '0;
        n_err       = '0;
        first_hit   = 1'b0;
        first_code  = '0;
        first_order = '0;
        first_chan  = '0;
        base_order  = '0;
        cnt_sum     = '0;
        rs1_a       = '0;
        rs2_a       = '0;
        rd_a        = '0;
        rs1_v       = '0;
        rs2_v       = '0;
        rd_v        = '0;
        ord_c       = '0;
        rs1_bad     = 1'b0;
        rs2_bad     = 1'b0;
        range_bad   = 1'b0;
        code_c      = '0;

        for (int unsigned k = 0; k < NRET; k++) begin
            rs1_a     = rvfi_rs1_addr[k*5 +: 5];
            rs2_a     = rvfi_rs2_addr[k*5 +: 5];
            rd_a      = rvfi_rd_addr[k*5 +: 5];
            rs1_v     = rvfi_rs1_rdata[k*XLEN +: XLEN];
            rs2_v     = rvfi_rs2_rdata[k*XLEN +: XLEN];
            rd_v      = rvfi_rd_wdata[k*XLEN +: XLEN];
            ord_c     = rvfi_order[k*64 +: 64];
            rs1_bad   = 1'b0;
            rs2_bad   = 1'b0;
            range_bad = !in_range(rs1_a) || !in_range(rs2_a) || !in_range(rd_a);
            code_c    = 4'd0;

            if (rvfi_valid[k]) begin
                if (nvalid == 3'd0) begin
                    base_order = ord_c;
                end

                if (rs1_a == 5'd0) begin
                    rs1_bad = (rs1_v != '0);
                end else if (in_range(rs1_a) && written_d[rs1_a[AW-1:0]]) begin
                    rs1_bad = (rs1_v != regs_d[rs1_a[AW-1:0]]);
                end
                if (rs2_a == 5'd0) begin
                    rs2_bad = (rs2_v != '0);
                end else if (in_range(rs2_a) && written_d[rs2_a[AW-1:0]]) begin
                    rs2_bad = (rs2_v != regs_d[rs2_a[AW-1:0]]);
                end

                // lowest code wins within a channel
                if (check && rs1_bad) begin
                    code_c = 4'd1;
                end else if (check && rs2_bad) begin
                    code_c = 4'd2;
                end else if (rd_a == 5'd0 && rd_v != '0) begin
                    code_c = 4'd3;
                end else if (check && state_q == ST_RUN &&
                             ord_c != exp_order_q + 64'(nvalid)) begin
                    code_c = 4'd4;
                end else if (range_bad) begin
                    code_c = 4'd5;
                end

                if (rd_a != 5'd0 && in_range(rd_a)) begin
                    regs_d[rd_a[AW-1:0]]    = rd_v;
                    written_d[rd_a[AW-1:0]] = 1'b1;
                end

                if (code_c != 4'd0) begin
                    n_err = n_err + 3'd1;
                    if (!first_hit) begin
                        first_hit   = 1'b1;
                        first_code  = code_c;
                        first_order = ord_c;
                        first_chan  = 2'(k);
                    end
                end
                nvalid = nvalid + 3'd1;
            end
        end

        if (state_q == ST_FAIL) begin
            // frozen: discard the walk's shadow updates
            regs_d    = regs_q;
            written_d = written_q;
        end else begin
            if (state_q == ST_INIT) begin
                if (nvalid != 3'd0) begin
                    exp_order_d = base_order + 64'(nvalid);
                    state_d     = ST_RUN;
                end
            end else begin
                exp_order_d = exp_order_q + 64'(nvalid);
            end

            if (n_err != 3'd0) begin
                if (!err_q) begin
                    err_d       = 1'b1;
                    err_code_d  = first_code;
                    err_order_d = first_order;
                    err_chan_d  = first_chan;
                end
                cnt_sum = {1'b0, err_count_q} + (CNT_W+1)'(n_err);
                err_count_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
                if (STOP_ON_ERROR) begin
                    state_d = ST_FAIL;
                end
            end
        end
    end

    // State, shadow file and error registers; async active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_INIT;
            regs_q      <= '{default: '0};
            written_q   <= '0;
            exp_order_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_order_q <= '0;
            err_chan_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            written_q   <= written_d;
            exp_order_q <= exp_order_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_order_q <= err_order_d;
            err_chan_q  <= err_chan_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_rvfi_regfile_check.sv
// Directed bench for rvfi_regfile_check: three instances cover single-channel
// stop-on-error, dual-channel forwarding, and continue-on-error with RV32E size.
module tb_rvfi_regfile_check;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // ---- DUT 1: NRET=1, STOP_ON_ERROR=1 ----
    logic        chk1 = 1'b1;
    logic        v1 = 1'b0;
    logic [63:0] o1 = '0;
    logic [4:0]  rs1a1 = '0, rs2a1 = '0, rda1 = '0;
    logic [31:0] rs1d1 = '0, rs2d1 = '0, rdd1 = '0;
    logic        err1;
    logic [3:0]  code1;
    logic [63:0] eord1;
    logic [1:0]  chan1;
    logic [15:0] cnt1;
    logic [1:0]  st1;

    rvfi_regfile_check #(.XLEN(32), .NRET(1), .NUM_REGS(32), .STOP_ON_ERROR(1'b1), .CNT_W(16)) u_dut1 (
        .clock(clk), .resetn(rst_n), .check(chk1), .rvfi_valid(v1), .rvfi_order(o1),
        .rvfi_rs1_addr(rs1a1), .rvfi_rs2_addr(rs2a1), .rvfi_rs1_rdata(rs1d1), .rvfi_rs2_rdata(rs2d1),
        .rvfi_rd_addr(rda1), .rvfi_rd_wdata(rdd1),
        .err(err1), .err_code(code1), .err_order(eord1), .err_chan(chan1), .err_count(cnt1), .state(st1)
    );

    // ---- DUT 2: NRET=2, STOP_ON_ERROR=1 ----
    logic         chk2 = 1'b1;
    logic [1:0]   v2 = '0;
    logic [127:0] o2 = '0;
    logic [9:0]   rs1a2 = '0, rs2a2 = '0, rda2 = '0;
    logic [63:0]  rs1d2 = '0, rs2d2 = '0, rdd2 = '0;
    logic         err2;
    logic [3:0]   code2;
    logic [63:0]  eord2;
    logic [1:0]   chan2;
    logic [15:0]  cnt2;
    logic [1:0]   st2;

    rvfi_regfile_check #(.XLEN(32), .NRET(2), .NUM_REGS(32), .STOP_ON_ERROR(1'b1), .CNT_W(16)) u_dut2 (
        .clock(clk), .resetn(rst_n), .check(chk2), .rvfi_valid(v2), .rvfi_order(o2),
        .rvfi_rs1_addr(rs1a2), .rvfi_rs2_addr(rs2a2), .rvfi_rs1_rdata(rs1d2), .rvfi_rs2_rdata(rs2d2),
        .rvfi_rd_addr(rda2), .rvfi_rd_wdata(rdd2),
        .err(err2), .err_code(code2), .err_order(eord2), .err_chan(chan2), .err_count(cnt2), .state(st2)
    );

    // ---- DUT 3: NRET=1, STOP_ON_ERROR=0, NUM_REGS=16 ----
    logic        chk3 = 1'b1;
    logic        v3 = 1'b0;
    logic [63:0] o3 = '0;
    logic [4:0]  rs1a3 = '0, rs2a3 = '0, rda3 = '0;
    logic [31:0] rs1d3 = '0, rs2d3 = '0, rdd3 = '0;
    logic        err3;
    logic [3:0]  code3;
    logic [63:0] eord3;
    logic [1:0]  chan3;
    logic [15:0] cnt3;
    logic [1:0]  st3;

    rvfi_regfile_check #(.XLEN(32), .NRET(1), .NUM_REGS(16), .STOP_ON_ERROR(1'b0), .CNT_W(16)) u_dut3 (
        .clock(clk), .resetn(rst_n), .check(chk3), .rvfi_valid(v3), .rvfi_order(o3),
        .rvfi_rs1_addr(rs1a3), .rvfi_rs2_addr(rs2a3), .rvfi_rs1_rdata(rs1d3), .rvfi_rs2_rdata(rs2d3),
        .rvfi_rd_addr(rda3), .rvfi_rd_wdata(rdd3),
        .err(err3), .err_code(code3), .err_order(eord3), .err_chan(chan3), .err_count(cnt3), .state(st3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one retire on DUT 1: drive on negedge, sample 1ns after the posedge
    task automatic cyc1(input logic [63:0] ord, input logic [4:0] ra, input logic [31:0] rd_,
                        input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        v1 = 1'b1; o1 = ord; rs1a1 = ra; rs1d1 = rd_; rda1 = wa; rdd1 = wd;
        rs2a1 = '0; rs2d1 = '0;
        @(posedge clk);
        #1;
        v1 = 1'b0;
    endtask

    // one cycle on DUT 2: ch0 may write, ch1 reads via rs2
    task automatic cyc2(input logic [1:0] vv, input logic [63:0] ord0, input logic [63:0] ord1,
                        input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] ra1, input logic [31:0] rd1);
        @(negedge clk);
        v2 = vv; o2 = {ord1, ord0};
        rda2 = {5'd0, wa0}; rdd2 = {32'd0, wd0};
        rs2a2 = {ra1, 5'd0}; rs2d2 = {rd1, 32'd0};
        rs1a2 = '0; rs1d2 = '0;
        @(posedge clk);
        #1;
        v2 = '0;
    endtask

    task automatic cyc3(input logic [63:0] ord, input logic [4:0] ra, input logic [31:0] rd_,
                        input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        v3 = 1'b1; o3 = ord; rs1a3 = ra; rs1d3 = rd_; rda3 = wa; rdd3 = wd;
        rs2a3 = '0; rs2d3 = '0;
        @(posedge clk);
        #1;
        v3 = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_err", 64'(err1), 64'd0);
        chk("rst_code", 64'(code1), 64'd0);
        chk("rst_order", eord1, 64'd0);
        chk("rst_cnt", 64'(cnt1), 64'd0);
        chk("rst_state", 64'(st1), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // DUT 1: write then good read, then bad read, then frozen
        cyc1(64'd0, 5'd0, 32'd0, 5'd5, 32'hDEADBEEF);
        chk("d1_init_to_run", 64'(st1), 64'd1);
        cyc1(64'd1, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
        chk("d1_good_err", 64'(err1), 64'd0);
        chk("d1_good_state", 64'(st1), 64'd1);
        cyc1(64'd2, 5'd5, 32'hDEADBEEE, 5'd0, 32'd0);
        chk("d1_bad_err", 64'(err1), 64'd1);
        chk("d1_bad_code", 64'(code1), 64'd1);
        chk("d1_bad_order", eord1, 64'd2);
        chk("d1_bad_chan", 64'(chan1), 64'd0);
        chk("d1_bad_state", 64'(st1), 64'd2);
        cyc1(64'd3, 5'd5, 32'h0, 5'd0, 32'd0);
        chk("d1_frozen_cnt", 64'(cnt1), 64'd1);
        chk("d1_frozen_order", eord1, 64'd2);

        // DUT 2: same-cycle forwarding, gap in valid channels, forwarded mismatch
        cyc2(2'b11, 64'd0, 64'd1, 5'd7, 32'h11, 5'd7, 32'h11);
        chk("d2_fwd_first_err", 64'(err2), 64'd0);
        cyc2(2'b11, 64'd2, 64'd3, 5'd7, 32'h44, 5'd7, 32'h44);
        chk("d2_fwd_new_err", 64'(err2), 64'd0);
        cyc2(2'b10, 64'd0, 64'd4, 5'd0, 32'h0, 5'd7, 32'h44);
        chk("d2_gap_err", 64'(err2), 64'd0);
        chk("d2_gap_state", 64'(st2), 64'd1);
        cyc2(2'b11, 64'd5, 64'd6, 5'd7, 32'h55, 5'd7, 32'h22);
        chk("d2_bad_code", 64'(code2), 64'd2);
        chk("d2_bad_chan", 64'(chan2), 64'd1);
        chk("d2_bad_order", eord2, 64'd6);
        chk("d2_bad_state", 64'(st2), 64'd2);

        // DUT 3: keep running after errors, count them, first code sticks
        cyc3(64'd0, 5'd0, 32'd0, 5'd5, 32'h1234);
        cyc3(64'd1, 5'd5, 32'h0, 5'd0, 32'd0);
        chk("d3_first_code", 64'(code3), 64'd1);
        chk("d3_first_state", 64'(st3), 64'd1);
        cyc3(64'd2, 5'd5, 32'h1234, 5'd0, 32'd5);
        chk("d3_x0_cnt", 64'(cnt3), 64'd2);
        cyc3(64'd3, 5'd5, 32'h1, 5'd0, 32'd0);
        chk("d3_three_cnt", 64'(cnt3), 64'd3);
        cyc3(64'd4, 5'd0, 32'd0, 5'd16, 32'h9);
        chk("d3_range_cnt", 64'(cnt3), 64'd4);
        chk("d3_code_kept", 64'(code3), 64'd1);
        chk("d3_order_kept", eord3, 64'd1);

        // asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_err1", 64'(err1), 64'd0);
        chk("async_state1", 64'(st1), 64'd0);
        chk("async_order1", eord1, 64'd0);
        chk("async_err2", 64'(err2), 64'd0);
        chk("async_cnt3", 64'(cnt3), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // DUT 1: unwritten read not compared; order gap 11 -> 13 flagged
        cyc1(64'd10, 5'd5, 32'h999, 5'd0, 32'd0);
        chk("d1_unwritten_err", 64'(err1), 64'd0);
        chk("d1_reinit_state", 64'(st1), 64'd1);
        cyc1(64'd11, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("d1_ord11_err", 64'(err1), 64'd0);
        cyc1(64'd13, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("d1_ord_code", 64'(code1), 64'd4);
        chk("d1_ord_order", eord1, 64'd13);
        chk("d1_ord_state", 64'(st1), 64'd2);

        // DUT 3 with check=0: same order gap is ignored
        chk3 = 1'b0;
        cyc3(64'd10, 5'd0, 32'd0, 5'd0, 32'd0);
        cyc3(64'd11, 5'd0, 32'd0, 5'd0, 32'd0);
        cyc3(64'd13, 5'd0, 32'd0, 5'd0, 32'd0);
        chk("d3_nochk_err", 64'(err3), 64'd0);
        chk("d3_nochk_state", 64'(st3), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
